// File: rtl/gpio_req_initiator_if.sv
// Handshake bundle between host-side control logic and the GPIO request initiator.
interface gpio_req_initiator_if;
    logic        start_i;
    logic        ack_i;
    logic        req_o;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [31:0] latency_o;

    // Initiator view: takes start/ack, drives request and status
    modport master (
        input  start_i, ack_i,
        output req_o, busy_o, done_o, timeout_o, latency_o
    );

    // Host/peer view
    modport slave (
        output start_i, ack_i,
        input  req_o, busy_o, done_o, timeout_o, latency_o
    );
endinterface

// File: rtl/gpio_req_initiator.sv
// Initiator side of the single-wire GPIO req/ack handshake.
// Raises req, measures cycles until the synchronized ack rises, drops req,
// waits for ack to fall. Each phase is bounded by TimeoutMax cycles.
module gpio_req_initiator #(
    parameter logic [31:0] TimeoutMax = 32'd4096,
    parameter int          SyncStages = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    gpio_req_initiator_if.master  bus
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StReq     = 2'd1;
    localparam logic [1:0] StRelease = 2'd2;

    logic [1:0]            state_q;
    logic [31:0]           cnt_q;
    logic [SyncStages-1:0] sync_q;
    logic                  ack_s;
    logic                  cnt_hit;
    logic                  to_flag_q;
    logic                  req_q;
    logic                  done_q;
    logic                  timeout_q;
    logic [31:0]           latency_q;

    // ack_i comes from the pad domain; shift it through SyncStages flops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[SyncStages-2:0], bus.ack_i};
    end

    assign ack_s = sync_q[SyncStages-1];

    // Saturating compare: cnt only advances below the bound, so it never wraps
    assign cnt_hit = (cnt_q >= TimeoutMax);

    // Handshake FSM; req/done/timeout are registered alongside the state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            to_flag_q <= 1'b0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            latency_q <= '0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    req_q <= 1'b0;
                    if (bus.start_i) begin
                        state_q   <= StReq;
                        req_q     <= 1'b1;
                        cnt_q     <= '0;
                        to_flag_q <= 1'b0;
                    end
                end
                StReq: begin
                    // ack wins over a timeout landing on the same cycle
                    if (ack_s) begin
                        latency_q <= cnt_q;
                        state_q   <= StRelease;
                        req_q     <= 1'b0;
                        cnt_q     <= '0;
                    end else if (cnt_hit) begin
                        timeout_q <= 1'b1;
                        to_flag_q <= 1'b1;
                        state_q   <= StRelease;
                        req_q     <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StRelease: begin
                    req_q <= 1'b0;
                    if (!ack_s) begin
                        state_q <= StIdle;
                        done_q  <= ~to_flag_q;
                    end else if (cnt_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_o     = req_q;
    assign bus.busy_o    = (state_q != StIdle);
    assign bus.done_o    = done_q;
    assign bus.timeout_o = timeout_q;
    assign bus.latency_o = latency_q;

endmodule

// File: doc/gpio_req_initiator.md
Name: gpio_req_initiator

Overview:
- Initiator side of the single-wire GPIO request/acknowledge handshake used by the GPIO counter peripheral.
- On a start pulse it raises req_o toward the peer's input, measures the cycles until the peer's acknowledge rises, drops req_o, and waits for the acknowledge to fall.
- Each phase is bounded by a timeout. Results (latency, done, timeout) go to the host-side control logic.

Parameters:
- TimeoutMax, 32'd4096, cycle bound per phase; must be < 2^32-1.
- SyncStages, 2, number of flops in the ack_i synchronizer; legal values 2..3.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- start_i  input  1  start request; sampled only in IDLE
- ack_i  input  1  acknowledge from peer (pad domain, asynchronous)
- req_o  output  1  request to peer, registered
- busy_o  output  1  high whenever state != IDLE
- done_o  output  1  one-cycle pulse: handshake completed without timeout
- timeout_o  output  1  one-cycle pulse: a phase timed out
- latency_o  output  32  cycles from req_o rise to synchronized ack; holds last value

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, cnt=0, synchronizer flops=0, req_o=0, done_o=0, timeout_o=0, latency_o=0, to_flag=0. Reset mid-handshake aborts it immediately with no pulse.
- ack_s is ack_i after SyncStages flops. The FSM uses only ack_s.
- IDLE:
  - req_o=0.
  - start_i=1: go to REQ, cnt<=0, to_flag<=0.
  - start_i=0: remain in IDLE.
- REQ:
  - req_o=1 from the first REQ cycle. cnt=k in the k-th REQ cycle (first cycle is 0).
  - ack_s=1: latency_o<=cnt, go to RELEASE, cnt<=0.
  - Else cnt==TimeoutMax: timeout_o pulses next cycle, to_flag<=1, go to RELEASE, cnt<=0. latency_o is unchanged.
  - Else: cnt<=cnt+1.
  - req_o is therefore high for at most TimeoutMax+1 cycles.
- RELEASE:
  - req_o=0.
  - ack_s=0: go to IDLE. done_o pulses in the first IDLE cycle if to_flag=0.
  - Else cnt==TimeoutMax: timeout_o pulses, go to IDLE, no done_o.
  - Else: cnt<=cnt+1.
- Latency definition (SyncStages=2):
  - Let req_o rise at edge E0.
  - If ack_i is first sampled high at edge E_D, then latency_o=D+1.
  - Against a gpio_cnt peer with CntMax=N, latency_o=N+4.
- Pulse and start rules:
  - done_o and timeout_o are registered and never assert in the same cycle.
  - A RELEASE timeout after a REQ timeout gives a second timeout_o pulse.
  - start_i while busy_o=1 is ignored (no queuing).
  - start_i in the cycle done_o is high is accepted.
- ack_s already high when REQ is entered: captured in the first REQ cycle, latency_o=0.
- ack_s dropping in RELEASE before cnt reaches TimeoutMax takes priority over timeout. In REQ, ack_s=1 takes priority over timeout on the same cycle.
- The counter compare saturates at TimeoutMax, so cnt never wraps.
- Unused or illegal state encoding goes to IDLE with req_o=0.

Test Plan:
- Reset: rst_ni low mid-REQ -> req_o=0, busy_o=0, latency_o=0 within the same cycle. After release the FSM is in IDLE.
- Basic handshake: start_i pulse; bench asserts ack_i sampled at E10, drops it 5 cycles after req_o falls -> latency_o=11, single done_o pulse, busy_o low afterwards.
- Loopback with gpio_cnt (CntMax=16): start_i -> latency_o=20, done_o=1, peer output back to 0.
- REQ timeout (TimeoutMax=8, ack_i held 0) -> req_o high exactly 9 cycles, one timeout_o pulse, no done_o, latency_o unchanged.
- Stuck ack (TimeoutMax=8, ack_i held 1 throughout) -> latency_o=0, RELEASE times out after 9 cycles, one timeout_o, FSM returns to IDLE.
- start_i held high continuously -> back-to-back handshakes; start_i ignored while busy. Each done_o cycle coincides with acceptance of the next start, so req_o rises the following cycle.
